// File: rtl/grc_frame_arbiter.sv
// grc_frame_arbiter: frame-granular round-robin word scheduler; define GRC_FRAME_ARB_GAP_EN for a one-cycle source-side gap between frames
module grc_frame_arbiter #(
    parameter int NUM_SRC = 4,
    parameter int WORD_BITS = 16,
    parameter int FRAME_LEN = 256,
    localparam int CW = $clog2(NUM_SRC)
) (
    input  logic                         clk,
    input  logic                         sync_reset,
    input  logic                         start_i,
    input  logic [NUM_SRC-1:0]           src_valid_i,
    input  logic [NUM_SRC*WORD_BITS-1:0] src_word_i,
    input  logic [NUM_SRC-1:0]           src_end_i,
    output logic [NUM_SRC-1:0]           src_ready_o,
    output logic [NUM_SRC-1:0]           src_enable_o,
    output logic                         valid_o,
    output logic [WORD_BITS-1:0]         word_o,
    output logic [CW-1:0]                chan_o,
    output logic                         sof_o,
    output logic                         eof_o,
    output logic                         trunc_o,
    output logic [31:0]                  frame_cnt_o,
    output logic                         done_o,
    input  logic                         ready_i
);
    localparam int BW = $clog2(FRAME_LEN);

    typedef enum logic [2:0] {
        IDLE,
        STREAM,
        ADVANCE,
`ifdef GRC_FRAME_ARB_GAP_EN
        GAP,
`endif
        DONE
    } state_t;

`ifdef GRC_FRAME_ARB_GAP_EN
    localparam state_t AFTER_ADV = GAP;
`else
    localparam state_t AFTER_ADV = STREAM;
`endif

    state_t               state_q, state_d;
    logic [CW-1:0]        g_q, g_d, nxt_g, idx;
    logic [NUM_SRC-1:0]   retire_q, retire_d, g_oh;
    logic [BW-1:0]        beat_q, beat_d;
    logic                 valid_q, valid_d, sof_q, sof_d, eof_q, eof_d, trunc_q, trunc_d;
    logic [WORD_BITS-1:0] word_q, word_d;
    logic [CW-1:0]        chan_q, chan_d;
    logic [31:0]          frame_cnt_q, frame_cnt_d;
    logic                 start_ok, in_stream, out_free, accept, end_take, last;

    assign start_ok  = start_i && (state_q == IDLE || state_q == DONE);
    assign in_stream = state_q == STREAM;
    assign g_oh      = NUM_SRC'(1) << g_q;
    assign out_free  = !valid_q || ready_i;
    assign accept    = in_stream && src_valid_i[g_q] && out_free;
    assign end_take  = in_stream && !accept && src_end_i[g_q];
    assign last      = beat_q == BW'(FRAME_LEN - 1);

    // next unretired source after g, scanning downwards so the nearest one wins and g itself is last
    always_comb begin
        nxt_g = g_q;
        idx = g_q;
        for (int k = NUM_SRC; k >= 1; k--) begin
            idx = CW'((int'(g_q) + k) % NUM_SRC);
            if (!retire_q[idx]) nxt_g = idx;
        end
    end

    // state register
    always_ff @(posedge clk) begin
        if (sync_reset) state_q <= IDLE;
        else state_q <= state_d;
    end

    // next-state logic: a frame ends on its last accepted beat or when the granted source ends
    always_comb begin
        state_d = state_q;
        if (start_ok) state_d = &src_end_i ? ADVANCE : STREAM;
        else if (in_stream && ((accept && last) || end_take)) state_d = ADVANCE;
        else if (state_q == ADVANCE) state_d = &retire_q ? DONE : AFTER_ADV;
`ifdef GRC_FRAME_ARB_GAP_EN
        else if (state_q == GAP) state_d = STREAM;
`endif
    end

    // datapath next values: grant pointer, retire mask, beat counter and the output register
    always_comb begin
        g_d         = start_ok ? '0 : (state_q == ADVANCE ? nxt_g : g_q);
        retire_d    = start_ok ? {NUM_SRC{&src_end_i}} : (end_take ? (retire_q | g_oh) : retire_q);
        beat_d      = (start_ok || end_take || (accept && last)) ? '0 : (accept ? beat_q + 1'b1 : beat_q);
        trunc_d     = end_take && beat_q != '0;
        frame_cnt_d = frame_cnt_q + 32'(accept && last);
        valid_d     = accept || (valid_q && !ready_i);
        word_d      = accept ? src_word_i[int'(g_q)*WORD_BITS +: WORD_BITS] : word_q;
        chan_d      = accept ? g_q : chan_q;
        sof_d       = accept ? beat_q == '0 : sof_q && valid_d;
        eof_d       = accept ? last : eof_q && valid_d;
    end

    // datapath registers; reset drops any word still waiting downstream
    always_ff @(posedge clk) begin
        if (sync_reset) begin
            g_q         <= '0;
            retire_q    <= '0;
            beat_q      <= '0;
            trunc_q     <= 1'b0;
            frame_cnt_q <= '0;
            valid_q     <= 1'b0;
            word_q      <= '0;
            chan_q      <= '0;
            sof_q       <= 1'b0;
            eof_q       <= 1'b0;
        end else begin
            g_q         <= g_d;
            retire_q    <= retire_d;
            beat_q      <= beat_d;
            trunc_q     <= trunc_d;
            frame_cnt_q <= frame_cnt_d;
            valid_q     <= valid_d;
            word_q      <= word_d;
            chan_q      <= chan_d;
            sof_q       <= sof_d;
            eof_q       <= eof_d;
        end
    end

    // state-decoded outputs: only the granted source sees enable/ready, and only while streaming
    always_comb begin
        src_enable_o = in_stream ? g_oh : '0;
        src_ready_o  = (in_stream && out_free) ? g_oh : '0;
        done_o       = state_q == DONE && !valid_q;
    end

    assign valid_o     = valid_q;
    assign word_o      = word_q;
    assign chan_o      = chan_q;
    assign sof_o       = sof_q;
    assign eof_o       = eof_q;
    assign trunc_o     = trunc_q;
    assign frame_cnt_o = frame_cnt_q;
endmodule

// File: doc/grc_frame_arbiter.md
# grc_frame_arbiter

Frame-granular round-robin scheduler for the channelizer simulation and streaming datapath. It shares one downstream word interface among NUM_SRC file-reader word sources. Each source has a valid/ready/end interface: an enable, a word stream, and a sticky end-of-buffer flag. The block grants one source at a time for up to FRAME_LEN words, retires sources that report end of buffer, and tags every output word with its source index and frame markers.

## Interface
- NUM_SRC, 4: number of word sources; ≥2.
- WORD_BITS, 16: word width.
- FRAME_LEN, 256: words per grant; ≥2.
- CW, $clog2(NUM_SRC): channel index width (local, not overridable).
- clk  in  1  single clock; all logic on rising edge.
- sync_reset  in  1  synchronous, active-high reset.
- start_i  in  1  one-cycle start pulse; honoured only in IDLE or DONE.
- src_valid_i  in  NUM_SRC  per-source word valid.
- src_word_i  in  NUM_SRC*WORD_BITS  source s on bits [s*WORD_BITS +: WORD_BITS].
- src_end_i  in  NUM_SRC  level; source has delivered its final word.
- src_ready_o  out  NUM_SRC  per-source ready; at most one bit set.
- src_enable_o  out  NUM_SRC  one-hot enable of the granted source in STREAM; 0 otherwise.
- valid_o  out  1  output word valid.
- word_o  out  WORD_BITS  output word.
- chan_o  out  CW  source index of word_o.
- sof_o / eof_o  out  1  first / last word of a full frame; qualified by valid_o.
- trunc_o  out  1  one-cycle pulse: granted source ended mid-frame.
- frame_cnt_o  out  32  completed full frames, wraps at 2^32.
- done_o  out  1  all sources retired and output drained.
- ready_i  in  1  downstream ready.

## Operation
- States: IDLE, STREAM, ADVANCE, GAP (macro only), DONE.
- Registers: grant pointer g, retire mask, beat counter beat (0..FRAME_LEN-1), output register.
- IDLE → STREAM on start_i:
  - clear retire mask, beat = 0, g = 0.
  - If src_end_i is all-ones at start, go to DONE after one ADVANCE.
- Output acceptance: out_free = !valid_o | ready_i.
- STREAM:
  - src_enable_o[g] = 1.
  - src_ready_o[g] = out_free.
  - Accept = src_valid_i[g] & src_ready_o[g].
  - On accept, load word_o and chan_o = g, set valid_o, sof_o = (beat == 0), eof_o = (beat == FRAME_LEN-1), then beat++.
  - On accepting beat FRAME_LEN-1: beat = 0, frame_cnt_o++, go to ADVANCE.
- End handling in STREAM: only in cycles with no accept and src_end_i[g] = 1.
  - Set retire mask bit g and go to ADVANCE.
  - If beat ≠ 0, pulse trunc_o and reset beat to 0.
  - A word and the end flag in the same cycle: the word is accepted and the end flag is evaluated on a later cycle.
- ADVANCE (one cycle):
  - Set g to the next unretired index after g, modulo NUM_SRC. g itself is eligible last.
  - If all sources are retired, go to DONE; otherwise go to STREAM.
- valid_o holds with a stable word until ready_i in every state. Backpressure never drops or duplicates words.
- DONE: done_o = !valid_o. start_i here behaves as in IDLE.
- sync_reset at any time, including mid-frame:
  - Go to IDLE; all outputs 0; g, beat and retire mask 0; frame_cnt_o = 0.
  - Any in-flight valid_o is discarded.

## Timing
- start_i at cycle n: STREAM and src_enable_o at n+1; earliest accept at n+1; valid_o at n+2.
- Latency is one cycle source-to-output. Throughput is one word per cycle with ready_i held high.
- Frame switch costs one dead cycle (ADVANCE) with the source bus idle. The output register may still drain during it.
- Retire mask update and trunc_o are registered: visible the cycle after end is sampled.
- done_o rises the cycle after the DONE entry cycle if the output is empty, otherwise the cycle after the final output handshake.

## Configuration
- GRC_FRAME_ARB_GAP_EN defined:
  - After ADVANCE, enter GAP for one cycle before STREAM.
  - src_enable_o = 0 and no accepts in GAP, giving a guaranteed one-cycle hole between frames on the source side.
- Undefined: ADVANCE goes directly to STREAM and the GAP state does not exist.

## Test plan
- NUM_SRC=4, FRAME_LEN=4, sources emit counters, ready_i=1, start_i → chan_o sequence 0,0,0,0,1,1,1,1,2,…; sof_o on beats 0, eof_o on beats 3; frame_cnt_o=4 after the first rotation.
- Source 1 raises src_end_i after 2 words of its frame → trunc_o pulses once; retire bit 1 set; later rotations go 0,2,3,0,…
- Random ready_i (50%) → output word stream per chan_o equals each source's stream with no loss or duplication; word_o stable while valid_o & !ready_i.
- All sources end → DONE; done_o high only once valid_o=0; a new start_i restarts from chan 0 with frame_cnt_o continuing.
- sync_reset asserted mid-frame with valid_o=1 → next cycle all outputs 0, state IDLE; start_i resumes at chan 0, beat 0.
- With GRC_FRAME_ARB_GAP_EN: exactly two source-idle cycles between frames (ADVANCE+GAP); without it, exactly one.
